// File: rtl/reg_status_table.sv
// -----------------------------------------------------------------------------
// reg_status_table
//
// Architectural register file with a per-register rename-tag table, placed
// between decode/dispatch and the reservation stations.
//
// Each register carries a data word and a producer tag. Tag 0 means the value
// is ready. A nonzero tag names the unit or slot that will produce the value.
//
// Writebacks retire by tag match, so a stale producer whose tag has already
// been replaced is silently dropped. Dispatch allocates new producer tags.
// A flush clears every tag for mispredict recovery.
//
// Optional feature (macro REG_STAT_BYPASS_EN):
//   When defined, a read of a register with a writeback committing this cycle
//   returns that writeback's data with tag 0, combinationally. When undefined,
//   reads see stored state only.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   rdy          global enable (low holds all state; reads stay live)
//   flush        clear all tags at the edge (overrides dispatch)
//   rd_en/rd_addr/rd_imm   NRD read ports (rd_en=0 passes the immediate)
//   rd_data/rd_tag         operand value and producer tag per read port
//   disp_en/disp_addr/disp_tag              NDISP tag-allocate channels
//   wb_en/wb_addr/wb_tag/wb_data            NWB writeback channels
//   locked_cnt   registered count of registers with a nonzero tag
// -----------------------------------------------------------------------------
module reg_status_table #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 3,
    parameter int NRD   = 4,
    parameter int NDISP = 2,
    parameter int NWB   = 3,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*AW-1:0]     rd_addr,
    input  logic [NRD*XLEN-1:0]   rd_imm,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD*TAG_W-1:0]  rd_tag,
    input  logic [NDISP-1:0]      disp_en,
    input  logic [NDISP*AW-1:0]   disp_addr,
    input  logic [NDISP*TAG_W-1:0] disp_tag,
    input  logic [NWB-1:0]        wb_en,
    input  logic [NWB*AW-1:0]     wb_addr,
    input  logic [NWB*TAG_W-1:0]  wb_tag,
    input  logic [NWB*XLEN-1:0]   wb_data,
    output logic [AW:0]           locked_cnt
);

    logic [XLEN-1:0]  r_data [NREG];
    logic [TAG_W-1:0] r_tag  [NREG];
    logic [AW:0]      r_locked_cnt;

    logic [XLEN-1:0]  w_nxt_data [NREG];
    logic [TAG_W-1:0] w_nxt_tag  [NREG];
    logic [AW:0]      w_nxt_cnt;
    logic [NWB-1:0]   w_wb_hit;

    // A writeback commits only when its tag still owns the register. Tags are
    // compared against the pre-edge table, so a same-cycle dispatch does not
    // hide a legitimate writeback.
    always_comb begin
        for (int k = 0; k < NWB; k++) begin
            w_wb_hit[k] = wb_en[k]
                       && (wb_addr[k*AW +: AW] != '0)
                       && (r_tag[wb_addr[k*AW +: AW]] == wb_tag[k*TAG_W +: TAG_W]);
        end
    end

    // Next-state table. Later loop iterations overwrite earlier ones, which
    // gives "highest channel wins" for both writeback and dispatch. Dispatch
    // is applied after writeback so a same-cycle allocation keeps its tag
    // while the data is still written.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_nxt_data[r] = r_data[r];
            w_nxt_tag[r]  = r_tag[r];
        end

        for (int k = 0; k < NWB; k++) begin
            if (w_wb_hit[k]) begin
                w_nxt_data[wb_addr[k*AW +: AW]] = wb_data[k*XLEN +: XLEN];
                w_nxt_tag[wb_addr[k*AW +: AW]]  = '0;
            end
        end

        if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                w_nxt_tag[r] = '0;
            end
        end else begin
            for (int j = 0; j < NDISP; j++) begin
                if (disp_en[j] && (disp_addr[j*AW +: AW] != '0)) begin
                    w_nxt_tag[disp_addr[j*AW +: AW]] = disp_tag[j*TAG_W +: TAG_W];
                end
            end
        end

        // x0 is never locked, so the count starts at register 1.
        w_nxt_cnt = '0;
        for (int r = 1; r < NREG; r++) begin
            if (w_nxt_tag[r] != '0) begin
                w_nxt_cnt = w_nxt_cnt + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_data[r] <= '0;
                r_tag[r]  <= '0;
            end
            r_locked_cnt <= '0;
        end else if (rdy) begin
            for (int r = 0; r < NREG; r++) begin
                r_data[r] <= w_nxt_data[r];
                r_tag[r]  <= w_nxt_tag[r];
            end
            r_locked_cnt <= w_nxt_cnt;
        end
    end

    // Combinational read ports.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_data[p*XLEN +: XLEN]  = '0;
            rd_tag[p*TAG_W +: TAG_W] = '0;
            if (!rd_en[p]) begin
                rd_data[p*XLEN +: XLEN] = rd_imm[p*XLEN +: XLEN];
            end else if (rd_addr[p*AW +: AW] != '0) begin
                rd_data[p*XLEN +: XLEN]  = r_data[rd_addr[p*AW +: AW]];
                rd_tag[p*TAG_W +: TAG_W] = r_tag[rd_addr[p*AW +: AW]];
`ifdef REG_STAT_BYPASS_EN
                // Forward only writebacks that will actually commit at this
                // edge; under reset or rdy=0 nothing commits.
                for (int k = 0; k < NWB; k++) begin
                    if (rdy && !rst && w_wb_hit[k]
                        && (wb_addr[k*AW +: AW] == rd_addr[p*AW +: AW])) begin
                        rd_data[p*XLEN +: XLEN]  = wb_data[k*XLEN +: XLEN];
                        rd_tag[p*TAG_W +: TAG_W] = '0;
                    end
                end
`endif
            end
        end
    end

    assign locked_cnt = r_locked_cnt;

endmodule

// File: tb/tb_reg_status_table.sv
module tb_reg_status_table;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int TAG_W = 3;
    localparam int NRD   = 4;
    localparam int NDISP = 2;
    localparam int NWB   = 3;
    localparam int AW    = $clog2(NREG);

    logic                   clk = 1'b0;
    logic                   rst, rdy, flush;
    logic [NRD-1:0]         rd_en;
    logic [NRD*AW-1:0]      rd_addr;
    logic [NRD*XLEN-1:0]    rd_imm;
    logic [NRD*XLEN-1:0]    rd_data;
    logic [NRD*TAG_W-1:0]   rd_tag;
    logic [NDISP-1:0]       disp_en;
    logic [NDISP*AW-1:0]    disp_addr;
    logic [NDISP*TAG_W-1:0] disp_tag;
    logic [NWB-1:0]         wb_en;
    logic [NWB*AW-1:0]      wb_addr;
    logic [NWB*TAG_W-1:0]   wb_tag;
    logic [NWB*XLEN-1:0]    wb_data;
    logic [AW:0]            locked_cnt;

    reg_status_table #(
        .XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W),
        .NRD(NRD), .NDISP(NDISP), .NWB(NWB)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_imm(rd_imm),
        .rd_data(rd_data), .rd_tag(rd_tag),
        .disp_en(disp_en), .disp_addr(disp_addr), .disp_tag(disp_tag),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data),
        .locked_cnt(locked_cnt)
    );

    always #5 clk = ~clk;

    // Reference state: what each architectural register holds.
    logic [XLEN-1:0]  m_data [NREG];
    logic [TAG_W-1:0] m_tag  [NREG];
    bit               m_valid = 0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_commit(input int k);
        logic [AW-1:0] a;
        a = wb_addr[k*AW +: AW];
        return wb_en[k] && (a != '0) && (m_tag[a] == wb_tag[k*TAG_W +: TAG_W]);
    endfunction

    function automatic int m_locked();
        int c = 0;
        for (int r = 0; r < NREG; r++) if (m_tag[r] != '0) c++;
        return c;
    endfunction

    // Compare every read port and the locked count against the reference.
    task automatic compare_model();
        logic [XLEN-1:0]  ed;
        logic [TAG_W-1:0] et;
        logic [AW-1:0]    a;
        if (!m_valid) return;
        for (int p = 0; p < NRD; p++) begin
            a = rd_addr[p*AW +: AW];
            if (!rd_en[p]) begin
                ed = rd_imm[p*XLEN +: XLEN]; et = '0;
            end else if (a == '0) begin
                ed = '0; et = '0;
            end else begin
                ed = m_data[a]; et = m_tag[a];
`ifdef REG_STAT_BYPASS_EN
                if (rdy && !rst) begin
                    for (int k = NWB - 1; k >= 0; k--) begin
                        if (m_commit(k) && wb_addr[k*AW +: AW] == a) begin
                            ed = wb_data[k*XLEN +: XLEN]; et = '0;
                            break;
                        end
                    end
                end
`endif
            end
            chk($sformatf("model rd_data[%0d]", p), 64'(rd_data[p*XLEN +: XLEN]), 64'(ed));
            chk($sformatf("model rd_tag[%0d]", p), 64'(rd_tag[p*TAG_W +: TAG_W]), 64'(et));
        end
        chk("model locked_cnt", 64'(locked_cnt), 64'(m_locked()));
    endtask

    // Per-register view of one clock edge.
    task automatic model_edge();
        logic [XLEN-1:0]  nd [NREG];
        logic [TAG_W-1:0] nt [NREG];
        int wk, dj;
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin m_data[r] = '0; m_tag[r] = '0; end
            m_valid = 1;
            return;
        end
        if (!rdy || !m_valid) return;
        for (int r = 0; r < NREG; r++) begin
            nd[r] = m_data[r]; nt[r] = m_tag[r];
            if (r == 0) continue;
            wk = -1;
            for (int k = NWB - 1; k >= 0; k--)
                if (wk < 0 && m_commit(k) && int'(wb_addr[k*AW +: AW]) == r) wk = k;
            dj = -1;
            for (int j = NDISP - 1; j >= 0; j--)
                if (dj < 0 && disp_en[j] && int'(disp_addr[j*AW +: AW]) == r) dj = j;
            if (wk >= 0) nd[r] = wb_data[wk*XLEN +: XLEN];
            if (flush)        nt[r] = '0;
            else if (dj >= 0) nt[r] = disp_tag[dj*TAG_W +: TAG_W];
            else if (wk >= 0) nt[r] = '0;
        end
        for (int r = 0; r < NREG; r++) begin m_data[r] = nd[r]; m_tag[r] = nt[r]; end
    endtask

    // Inputs are set just after a negedge; this checks, crosses the posedge,
    // advances the reference, and returns at the next negedge.
    task automatic cycle();
        #1 compare_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rst = 0; rdy = 1; flush = 0;
        rd_en = '0; rd_addr = '0; rd_imm = '0;
        disp_en = '0; disp_addr = '0; disp_tag = '0;
        wb_en = '0; wb_addr = '0; wb_tag = '0; wb_data = '0;
    endtask

    task automatic set_rd(input int p, input bit en, input int a, input logic [XLEN-1:0] imm);
        rd_en[p] = en; rd_addr[p*AW +: AW] = AW'(a); rd_imm[p*XLEN +: XLEN] = imm;
    endtask

    task automatic set_disp(input int j, input int a, input int t);
        disp_en[j] = 1'b1; disp_addr[j*AW +: AW] = AW'(a); disp_tag[j*TAG_W +: TAG_W] = TAG_W'(t);
    endtask

    task automatic set_wb(input int k, input int a, input int t, input logic [XLEN-1:0] d);
        wb_en[k] = 1'b1; wb_addr[k*AW +: AW] = AW'(a);
        wb_tag[k*TAG_W +: TAG_W] = TAG_W'(t); wb_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic lit_rd(input string name, input int p, input logic [XLEN-1:0] d, input int t);
        chk({name, " data"}, 64'(rd_data[p*XLEN +: XLEN]), 64'(d));
        chk({name, " tag"}, 64'(rd_tag[p*TAG_W +: TAG_W]), 64'(t));
    endtask

    initial begin
        int a;
        clear_inputs();
        rst = 1;
        @(negedge clk);
        cycle();
        cycle();

        // Reset state and immediate pass-through.
        clear_inputs();
        set_rd(0, 1, 5, '0);
        set_rd(1, 0, 0, 32'h1234);
        #1;
        lit_rd("reset x5", 0, '0, 0);
        lit_rd("imm", 1, 32'h1234, 0);
        chk("reset locked_cnt", 64'(locked_cnt), 64'd0);
        cycle();

        // Dispatch then matching writeback.
        clear_inputs(); set_disp(0, 5, 3); cycle();
        clear_inputs(); set_rd(0, 1, 5, '0); set_wb(0, 5, 3, 32'hDEAD);
        #1;
`ifdef REG_STAT_BYPASS_EN
        lit_rd("bypass x5", 0, 32'hDEAD, 0);
`else
        lit_rd("locked x5", 0, '0, 3);
`endif
        chk("locked_cnt one", 64'(locked_cnt), 64'd1);
        cycle();
        clear_inputs(); set_rd(0, 1, 5, '0);
        #1;
        lit_rd("wb x5", 0, 32'hDEAD, 0);
        chk("locked_cnt zero", 64'(locked_cnt), 64'd0);
        cycle();

        // Stale writeback dropped.
        clear_inputs(); set_disp(0, 5, 3); cycle();
        clear_inputs(); set_wb(0, 5, 2, 32'h1); cycle();
        clear_inputs(); set_rd(0, 1, 5, '0);
        #1 lit_rd("stale wb x5", 0, 32'hDEAD, 3);
        cycle();

        // Two dispatches plus a matching writeback to one register.
        clear_inputs(); set_disp(0, 7, 2); cycle();
        clear_inputs(); set_disp(0, 7, 1); set_disp(1, 7, 4); set_wb(0, 7, 2, 32'h55); cycle();
        clear_inputs(); set_rd(0, 1, 7, '0);
        #1 lit_rd("disp+wb x7", 0, 32'h55, 4);
        chk("locked_cnt two", 64'(locked_cnt), 64'd2);
        cycle();

        // Flush overrides dispatch.
        clear_inputs(); set_disp(0, 3, 1); set_disp(1, 4, 2); cycle();
        clear_inputs(); set_disp(0, 6, 3); cycle();
        clear_inputs();
        #1 chk("locked_cnt five", 64'(locked_cnt), 64'd5);
        cycle();
        clear_inputs(); flush = 1; set_disp(0, 9, 5); cycle();
        clear_inputs(); set_rd(0, 1, 9, '0); set_rd(1, 1, 3, '0);
        #1;
        lit_rd("flush x9", 0, '0, 0);
        lit_rd("flush x3", 1, '0, 0);
        chk("flush locked_cnt", 64'(locked_cnt), 64'd0);
        cycle();

        // x0 is immune to dispatch and writeback.
        clear_inputs(); set_disp(0, 0, 1); set_wb(0, 0, 0, 32'hFFFF); cycle();
        clear_inputs(); set_rd(0, 1, 0, '0);
        #1;
        lit_rd("x0", 0, '0, 0);
        chk("x0 locked_cnt", 64'(locked_cnt), 64'd0);
        cycle();

        // rdy=0 holds state.
        clear_inputs(); rdy = 0; set_disp(0, 5, 3); cycle();
        clear_inputs(); set_rd(0, 1, 5, '0);
        #1 lit_rd("rdy hold x5", 0, 32'hDEAD, 0);
        cycle();

        // Randomized traffic on a small address window to force collisions.
        for (int c = 0; c < 3000; c++) begin
            clear_inputs();
            rst   = ($urandom_range(0, 199) == 0);
            rdy   = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 19) == 0);
            for (int p = 0; p < NRD; p++)
                set_rd(p, $urandom_range(0, 5) != 0, $urandom_range(0, 9), XLEN'($urandom));
            for (int j = 0; j < NDISP; j++) begin
                if ($urandom_range(0, 1) != 0)
                    set_disp(j, $urandom_range(0, 9), $urandom_range(1, (1 << TAG_W) - 1));
            end
            for (int k = 0; k < NWB; k++) begin
                if ($urandom_range(0, 1) != 0) begin
                    a = $urandom_range(0, 9);
                    if ($urandom_range(0, 3) != 0)
                        set_wb(k, a, int'(m_tag[a]), XLEN'($urandom));
                    else
                        set_wb(k, a, $urandom_range(0, (1 << TAG_W) - 1), XLEN'($urandom));
                end
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
